// File: rtl/ps2_pkg.sv
// Shared scan-code constants, arrow/state encodings and scan-code lookup for the
// PS/2 arrow-key decoder.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    ARW_UP    = 2'd0,
    ARW_DOWN  = 2'd1,
    ARW_LEFT  = 2'd2,
    ARW_RIGHT = 2'd3
  } arrow_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } dec_state_e;

  typedef struct packed {
    logic   hit;
    arrow_e key;
  } arrow_hit_t;

  // Same byte values serve both E0-prefixed arrows and the keypad 8/2/4/6 codes.
  function automatic arrow_hit_t arrow_lookup(input logic [7:0] code);
    arrow_hit_t r;
    r = '{hit: 1'b0, key: ARW_UP};
    case (code)
      SC_UP:    r = '{hit: 1'b1, key: ARW_UP};
      SC_DOWN:  r = '{hit: 1'b1, key: ARW_DOWN};
      SC_LEFT:  r = '{hit: 1'b1, key: ARW_LEFT};
      SC_RIGHT: r = '{hit: 1'b1, key: ARW_RIGHT};
      default:  r = '{hit: 1'b0, key: ARW_UP};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_flag_sync.sv
// Brings the receiver's byte-complete flag into the system clock domain and turns
// each rising edge into a single-cycle strobe.
module ps2_flag_sync (
  input  logic clk,
  input  logic rst,
  input  logic flag,
  output logic strobe
);

  logic sync1, sync2, sync3;

  // Reset to 1 so a flag already high through reset never looks like a new byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= flag;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign strobe = sync2 & ~sync3;

endmodule

// File: rtl/ps2_arrow_decoder.sv
// Parses PS/2 make/break/E0 sequences into press/release pulses and a held bitmap
// for the four arrow keys, with typematic filtering and prefix timeout.
module ps2_arrow_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC   = 1_000_000,
  parameter bit ACCEPT_KEYPAD = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_code,
  input  logic       i_code_valid,
  output logic [3:0] o_held,
  output logic [1:0] o_key,
  output logic       o_press,
  output logic       o_release,
  output logic       o_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYC);

  logic       strobe;
  arrow_hit_t hit;
  logic [1:0] bit_idx;
  dec_state_e state, state_nxt;
  logic       ev_make, ev_break, expire;
  logic [CW-1:0] cnt;

  ps2_flag_sync u_sync (
    .clk    (i_clk),
    .rst    (i_rst),
    .flag   (i_code_valid),
    .strobe (strobe)
  );

  assign hit = arrow_lookup(i_code);
  // Up sits in the MSB of the bitmap, right in the LSB.
  assign bit_idx = 2'(2'd3 - 2'(hit.key));

  always_comb begin
    state_nxt = state;
    ev_make   = 1'b0;
    ev_break  = 1'b0;
    if (strobe) begin
      case (state)
        ST_IDLE: begin
          if (i_code == SC_EXT)      state_nxt = ST_EXT;
          else if (i_code == SC_BRK) state_nxt = ST_BRK;
          else                       ev_make   = hit.hit & ACCEPT_KEYPAD;
        end
        ST_EXT: begin
          if (i_code == SC_BRK) state_nxt = ST_EXT_BRK;
          else begin
            state_nxt = ST_IDLE;
            ev_make   = hit.hit;
          end
        end
        ST_BRK: begin
          state_nxt = ST_IDLE;
          ev_break  = hit.hit & ACCEPT_KEYPAD;
        end
        ST_EXT_BRK: begin
          state_nxt = ST_IDLE;
          ev_break  = hit.hit;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Fires as the counter would reach TIMEOUT_CYC-1; a same-cycle strobe takes priority.
  assign expire = (state != ST_IDLE) && !strobe && (cnt == CW'(TIMEOUT_CYC - 2));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      o_held    <= 4'b0000;
      o_key     <= 2'd0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_timeout <= 1'b0;
      if (expire) begin
        state     <= ST_IDLE;
        cnt       <= '0;
        o_timeout <= 1'b1;
      end else begin
        state <= state_nxt;
        cnt   <= (strobe || state == ST_IDLE) ? '0 : cnt + CW'(1);
      end
      if (ev_make && !o_held[bit_idx]) begin
        o_held[bit_idx] <= 1'b1;
        o_key           <= 2'(hit.key);
        o_press         <= 1'b1;
      end
      if (ev_break && o_held[bit_idx]) begin
        o_held[bit_idx] <= 1'b0;
        o_key           <= 2'(hit.key);
        o_release       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// Directed bench: two decoders (keypad accepted / rejected, short timeout) fed the
// same byte stream; table-driven sequences plus cycle-exact latency/timeout cases.
module tb_ps2_arrow_decoder;

  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] code = 8'h75;
  logic valid = 1'b1;

  logic [3:0] held_a, held_b;
  logic [1:0] key_a, key_b;
  logic press_a, rel_a, tmo_a, press_b, rel_b, tmo_b;

  always #5 clk = ~clk;

  ps2_arrow_decoder #(.TIMEOUT_CYC(16), .ACCEPT_KEYPAD(1'b1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_code(code), .i_code_valid(valid),
    .o_held(held_a), .o_key(key_a), .o_press(press_a), .o_release(rel_a), .o_timeout(tmo_a));

  ps2_arrow_decoder #(.TIMEOUT_CYC(16), .ACCEPT_KEYPAD(1'b0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_code(code), .i_code_valid(valid),
    .o_held(held_b), .o_key(key_b), .o_press(press_b), .o_release(rel_b), .o_timeout(tmo_b));

  int pa = 0, ra = 0, ta = 0, pb = 0, rb = 0, tb = 0;
  always @(negedge clk) begin
    if (!rst) begin
      pa <= pa + int'(press_a); ra <= ra + int'(rel_a); ta <= ta + int'(tmo_a);
      pb <= pb + int'(press_b); rb <= rb + int'(rel_b); tb <= tb + int'(tmo_b);
    end
  end

  int n_cmp = 0, n_fail = 0;
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] code;
    int ap, ar; logic [3:0] ah; int ak;
    int bp, br; logic [3:0] bh; int bk;
  } vec_t;
  vec_t vt[$];

  task automatic add(input logic [7:0] c, input int ap, input int ar, input logic [3:0] ah,
                     input int ak, input int bp, input int br, input logic [3:0] bh, input int bk);
    vec_t v;
    v.code = c; v.ap = ap; v.ar = ar; v.ah = ah; v.ak = ak;
    v.bp = bp; v.br = br; v.bh = bh; v.bk = bk;
    vt.push_back(v);
  endtask

  // Flag high 4 cycles, low 4 cycles: comfortably meets the upstream contract.
  task automatic send_byte(input logic [7:0] c);
    @(negedge clk);
    code = c; valid = 1'b1;
    repeat (4) @(negedge clk);
    valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic rise(input logic [7:0] c);
    code = c; valid = 1'b1;
  endtask

  int p0a, r0a, t0a, p0b, r0b, t0b;

  initial begin
    // Reset with flag held high, then release: no strobe may appear
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_held_a", held_a, 0);
    chk("rst_key_a", key_a, 0);
    chk("rst_press_a", pa, 0);
    chk("rst_held_b", held_b, 0);
    chk("rst_tmo_a", ta, 0);
    valid = 1'b0;
    repeat (4) @(negedge clk);

    // Latency: press pulse exactly at the 3rd edge after the flag rise
    send_byte(8'hE0);
    @(negedge clk);
    rise(8'h75);
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("lat_press_e%0d", e), press_a, (e == 3) ? 1 : 0);
      if (e == 3) begin
        chk("lat_key", key_a, 0);
        chk("lat_held", held_a, 4'b1000);
      end
      if (e == 4) valid = 1'b0;
    end
    repeat (4) @(negedge clk);
    p0a = pa; r0a = ra;
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    chk("lat_rel_cnt", ra - r0a, 1);
    chk("lat_rel_held", held_a, 0);
    chk("lat_rel_press_cnt", pa - p0a, 0);

    // Table: code, A{press,rel,held,key}, B{press,rel,held,key}
    add(8'hE0, 0,0,4'b0000,0, 0,0,4'b0000,0);
    add(8'h75, 1,0,4'b1000,0, 1,0,4'b1000,0);
    add(8'hE0, 0,0,4'b1000,0, 0,0,4'b1000,0);
    add(8'hF0, 0,0,4'b1000,0, 0,0,4'b1000,0);
    add(8'h75, 0,1,4'b0000,0, 0,1,4'b0000,0);
    add(8'hE0, 0,0,4'b0000,0, 0,0,4'b0000,0);
    add(8'h74, 1,0,4'b0001,3, 1,0,4'b0001,3);
    add(8'hE0, 0,0,4'b0001,3, 0,0,4'b0001,3);
    add(8'h74, 0,0,4'b0001,3, 0,0,4'b0001,3);
    add(8'hE0, 0,0,4'b0001,3, 0,0,4'b0001,3);
    add(8'h74, 0,0,4'b0001,3, 0,0,4'b0001,3);
    add(8'hE0, 0,0,4'b0001,3, 0,0,4'b0001,3);
    add(8'hF0, 0,0,4'b0001,3, 0,0,4'b0001,3);
    add(8'h74, 0,1,4'b0000,3, 0,1,4'b0000,3);
    add(8'hE0, 0,0,4'b0000,3, 0,0,4'b0000,3);
    add(8'h75, 1,0,4'b1000,0, 1,0,4'b1000,0);
    add(8'hE0, 0,0,4'b1000,0, 0,0,4'b1000,0);
    add(8'h6B, 1,0,4'b1010,2, 1,0,4'b1010,2);
    add(8'hE0, 0,0,4'b1010,2, 0,0,4'b1010,2);
    add(8'hF0, 0,0,4'b1010,2, 0,0,4'b1010,2);
    add(8'h75, 0,1,4'b0010,0, 0,1,4'b0010,0);
    add(8'hE0, 0,0,4'b0010,0, 0,0,4'b0010,0);
    add(8'hF0, 0,0,4'b0010,0, 0,0,4'b0010,0);
    add(8'h6B, 0,1,4'b0000,2, 0,1,4'b0000,2);
    add(8'h72, 1,0,4'b0100,1, 0,0,4'b0000,2);
    add(8'hF0, 0,0,4'b0100,1, 0,0,4'b0000,2);
    add(8'h72, 0,1,4'b0000,1, 0,0,4'b0000,2);
    add(8'h1C, 0,0,4'b0000,1, 0,0,4'b0000,2);
    add(8'hF0, 0,0,4'b0000,1, 0,0,4'b0000,2);
    add(8'h1C, 0,0,4'b0000,1, 0,0,4'b0000,2);

    foreach (vt[i]) begin
      p0a = pa; r0a = ra; t0a = ta; p0b = pb; r0b = rb; t0b = tb;
      send_byte(vt[i].code);
      chk($sformatf("v%0d_press_a", i), pa - p0a, vt[i].ap);
      chk($sformatf("v%0d_rel_a", i), ra - r0a, vt[i].ar);
      chk($sformatf("v%0d_held_a", i), held_a, vt[i].ah);
      chk($sformatf("v%0d_key_a", i), key_a, vt[i].ak);
      chk($sformatf("v%0d_tmo_a", i), ta - t0a, 0);
      chk($sformatf("v%0d_press_b", i), pb - p0b, vt[i].bp);
      chk($sformatf("v%0d_rel_b", i), rb - r0b, vt[i].br);
      chk($sformatf("v%0d_held_b", i), held_b, vt[i].bh);
      chk($sformatf("v%0d_key_b", i), key_b, vt[i].bk);
      chk($sformatf("v%0d_tmo_b", i), tb - t0b, 0);
    end

    // Timeout: E0 consumed at edge 3, abandoned 15 edges later (edge 18)
    @(negedge clk);
    rise(8'hE0);
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("tmo_a_e%0d", e), tmo_a, (e == 18) ? 1 : 0);
      chk($sformatf("tmo_b_e%0d", e), tmo_b, (e == 18) ? 1 : 0);
      if (e == 4) valid = 1'b0;
    end
    chk("tmo_held_a", held_a, 0);
    p0a = pa; p0b = pb;
    send_byte(8'h6B);
    chk("post_tmo_press_b", pb - p0b, 0);
    chk("post_tmo_press_a", pa - p0a, 1);
    chk("post_tmo_key_a", key_a, 2);
    send_byte(8'hF0); send_byte(8'h6B);
    chk("post_tmo_held_a", held_a, 0);

    // Strobe lands on the timeout cycle: byte wins, no timeout pulse
    t0a = ta; t0b = tb;
    @(negedge clk);
    rise(8'hE0);
    for (int e = 1; e <= 22; e++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("col_tmo_a_e%0d", e), tmo_a, 0);
      if (e >= 16 && e <= 20) begin
        chk($sformatf("col_press_a_e%0d", e), press_a, (e == 18) ? 1 : 0);
        chk($sformatf("col_press_b_e%0d", e), press_b, (e == 18) ? 1 : 0);
      end
      if (e == 4) valid = 1'b0;
      if (e == 15) rise(8'h75);
      if (e == 19) valid = 1'b0;
    end
    chk("col_held_a", held_a, 4'b1000);
    chk("col_held_b", held_b, 4'b1000);
    chk("col_tmo_cnt_b", tb - t0b, 0);
    repeat (4) @(negedge clk);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    chk("col_rel_held_a", held_a, 0);

    // Reset mid-hold clears the bitmap with no release events
    send_byte(8'hE0); send_byte(8'h74);
    chk("mid_held_a", held_a, 4'b0001);
    r0a = ra;
    send_byte(8'hE0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_held_a", held_a, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_rel_cnt", ra - r0a, 0);
    p0a = pa;
    send_byte(8'h74);
    chk("mid_rst_noprefix_press", pa - p0a, 1);
    chk("mid_rst_noprefix_held", held_a, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_arrow_decoder.md
# ps2_arrow_decoder

Sits directly downstream of the PS/2 byte receiver: it takes the received scan-code byte and its completion flag, brings the flag into the `i_clk` domain, and parses make/break/extended-prefix sequences. It produces clean one-cycle press/release events and a held-key bitmap for the four arrow keys, filtering typematic repeats and abandoning stale prefix sequences after a timeout. Its outputs feed game/control logic directly in the `i_clk` domain.

## Interface
- `TIMEOUT_CYC`, default 1_000_000: `i_clk` cycles a prefix state may wait for its next byte before abandoning the sequence (≥ 4).
- `ACCEPT_KEYPAD`, default 1: when 1, non-E0 codes 75/72/6B/74 (keypad 8/2/4/6) are treated as arrows. When 0, only E0-prefixed codes count.
- `i_clk` input 1: system clock; all outputs are registered on its rising edge.
- `i_rst` input 1: asynchronous, active-high reset.
- `i_code` input 8: last received scan-code byte from the receiver. Stable while `i_code_valid` is high.
- `i_code_valid` input 1: receiver completion flag, in the PS/2 clock domain. High for about one PS/2 bit time per byte.
- `o_held` output 4: held bitmap {up, down, left, right} = bits [3:0].
- `o_key` output 2: key of the latest event (UP=0, DOWN=1, LEFT=2, RIGHT=3). Holds its value between events.
- `o_press` output 1: one-cycle pulse, new press of `o_key`.
- `o_release` output 1: one-cycle pulse, release of `o_key`.
- `o_timeout` output 1: one-cycle pulse when a prefix sequence is abandoned.

## Operation
- Reset values:
  - `o_held`=0, `o_key`=0, `o_press`/`o_release`/`o_timeout`=0.
  - FSM in IDLE, timeout counter 0.
  - Synchronizer stages all 1, so a flag that is already high through reset is never counted as a new byte.
- Byte strobe: `i_code_valid` passes a 2-FF synchronizer. A third register provides rising-edge detect. Strobe = sync2 & ~sync3, exactly one cycle per byte. `i_code` is sampled only on the strobe cycle; it is not synchronized.
- FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0). On a strobe:
  - IDLE: E0→EXT; F0→BRK; arrow code and ACCEPT_KEYPAD→make; anything else stays in IDLE.
  - EXT: F0→EXT_BRK; arrow code→make, then IDLE; anything else→IDLE.
  - BRK: arrow code and ACCEPT_KEYPAD→break; all bytes→IDLE.
  - EXT_BRK: arrow code→break; all bytes→IDLE.
- Make of key k:
  - If `o_held[k]`=0: set `o_held[k]`, `o_key`=k, pulse `o_press`.
  - If `o_held[k]`=1 (typematic repeat): no output change.
- Break of key k:
  - If `o_held[k]`=1: clear `o_held[k]`, `o_key`=k, pulse `o_release`.
  - Otherwise: no output change.
- Timeout: the counter runs only in EXT/BRK/EXT_BRK and clears on every strobe and on entry to IDLE. When it reaches TIMEOUT_CYC−1 without a strobe: go to IDLE, pulse `o_timeout`. `o_held` is untouched.
- Simultaneous strobe and timeout in one cycle: the strobe wins, the byte is processed normally, no `o_timeout`.
- At most one of `o_press`/`o_release` pulses per cycle. Events are ≥ 1 PS/2 byte apart.
- Asserting `i_rst` mid-sequence discards any partial prefix and clears `o_held`. No release events are emitted for the keys that were held.

## Timing
- Latency: the synchronizer first sees `i_code_valid` high at edge 1. The strobe is high after edge 2. FSM, `o_held`, `o_key` and the pulses update at edge 3.
- Pulses are exactly one `i_clk` cycle wide.
- Upstream contract: `i_code` stable for ≥ 3 `i_clk` cycles after `i_code_valid` rises. This holds when the `i_clk` period is below one third of the PS/2 clock period.
- Back-to-back bytes: a new strobe requires `i_code_valid` to be low for ≥ 2 `i_clk` cycles first.

## Structure
- Shared package `ps2_pkg`:
  - Constants SC_EXT=8'hE0, SC_BRK=8'hF0, SC_UP=8'h75, SC_DOWN=8'h72, SC_LEFT=8'h6B, SC_RIGHT=8'h74.
  - Enum `arrow_e` (2-bit, encoding as `o_key`).
  - Enum `dec_state_e` (IDLE/EXT/BRK/EXT_BRK).
  - Function mapping a scan code to `arrow_e` plus a hit bit.
- One sub-module: `ps2_flag_sync`, holding the 2-FF synchronizer, edge-detect register and strobe output, with set-to-1 on reset.

## Test plan
- Reset with `i_code_valid` held high, then release: no strobe, all outputs 0.
- E0,75 → `o_press` pulse 3 cycles after the flag rise, `o_key`=0, `o_held`=4'b1000. Then E0,F0,75 → `o_release`, `o_held`=0.
- Typematic: E0,74 sent three times → exactly one `o_press` (`o_key`=3), `o_held`=4'b0001.
- Overlapping keys: press up, then press left, then release up → `o_held` goes 1000, 1010, 0010, with 3 distinct pulses and matching `o_key`.
- ACCEPT_KEYPAD=0: plain 72 and F0,72 → no events. Same test with ACCEPT_KEYPAD=1 → press then release, `o_key`=1.
- TIMEOUT_CYC=16: send E0, then nothing → `o_timeout` pulse 15 cycles after the E0 strobe, state IDLE. Then plain 6B with ACCEPT_KEYPAD=0 → no event. Also time a byte strobe on the timeout cycle → the byte is processed and no `o_timeout` pulse.
